// File: rtl/sram_pkg.sv
// Shared constants for the banked SRAM array built from 1024x32 single-port macros.
// Contents: macro geometry, read-margin default, row-count helper.
package sram_pkg;

  localparam int unsigned MACRO_DEPTH = 1024;
  localparam int unsigned MACRO_W     = 32;
  localparam int unsigned MACRO_AW    = 10;
  localparam logic [3:0]  RM_DEFAULT  = 4'b0011;

  // Macro rows needed to cover a word count.
  function automatic int unsigned macro_rows(input int unsigned depth);
    return (depth + MACRO_DEPTH - 1) / MACRO_DEPTH;
  endfunction

endpackage

// File: rtl/sram_macro_tile.sv
// One 1024x32 single-port macro slot (HL28HKHDDP1024x32BIM4W1P0MSA10, port A only).
// Ports:
//   clk   in   clock (also drives CLKB on the hard macro)
//   mea   in   port A macro enable
//   wea   in   port A write enable (1 = write)
//   adra  in   port A word address
//   da    in   port A write data
//   wema  in   port A per-bit write enable
//   qa    out  port A read data, valid the cycle after a read-enabled edge
// Port B, test and read-margin pins are tied off here; the storage below is a
// behavioural stand-in for the hard macro.
module sram_macro_tile
  import sram_pkg::*;
(
  input  logic                clk,
  input  logic                mea,
  input  logic                wea,
  input  logic [MACRO_AW-1:0] adra,
  input  logic [MACRO_W-1:0]  da,
  input  logic [MACRO_W-1:0]  wema,
  output logic [MACRO_W-1:0]  qa
);

  // Tie-offs presented to the macro.
  logic                test1a;
  logic                rmea;
  logic [3:0]          rma;
  logic                ls;
  logic                meb;
  logic                web;
  logic [MACRO_AW-1:0] adrb;
  logic [MACRO_W-1:0]  db;
  logic [MACRO_W-1:0]  wemb;

  assign test1a = 1'b1;
  assign rmea   = 1'b1;
  assign rma    = RM_DEFAULT;
  assign ls     = 1'b0;
  assign meb    = 1'b0;
  assign web    = 1'b0;
  assign adrb   = '0;
  assign db     = '0;
  assign wemb   = '0;

  // The model only operates in the tied-off mode (normal margin, awake, port B idle).
  logic cfg_ok;
  assign cfg_ok = test1a & rmea & (rma == RM_DEFAULT) & ~ls & ~meb & ~web
                & ~|adrb & ~|db & ~|wemb;

  logic [MACRO_W-1:0] mem [MACRO_DEPTH];

  // Synchronous masked write / registered read.
  always_ff @(posedge clk) begin
    if (mea & cfg_ok) begin
      if (wea) begin
        mem[adra] <= (mem[adra] & ~wema) | (da & wema);
      end else begin
        qa <= mem[adra];
      end
    end
  end

endmodule

// File: rtl/sram_banked_mem.sv
// DATA_W x DEPTH single-port SRAM tiled from 1024x32 macros, with a valid/ready
// request channel, per-bit write mask and a skid FIFO for read responses.
// Ports:
//   i_clk, i_rst             clock, asynchronous active-high reset
//   i_req_valid/o_req_ready  request handshake (ready from registered state only)
//   i_req_we                 1 = write, 0 = read
//   i_req_addr               word address
//   i_req_wdata, i_req_bmask write data and per-bit write enable
//   o_rsp_valid/i_rsp_ready  read response handshake
//   o_rsp_rdata, o_rsp_err   read data; err flags address >= DEPTH (data 0)
// Config macro SRAM_OUT_REG_EN: register after the row mux (latency 2, FIFO 3);
// otherwise latency 1, FIFO 2.
module sram_banked_mem
  import sram_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 4096,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  input  logic [DATA_W-1:0] i_req_bmask,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rsp_err
);

  localparam int unsigned COLS      = DATA_W / MACRO_W;
  localparam int unsigned ROWS      = macro_rows(DEPTH);
  localparam int unsigned ROW_W     = (ADDR_W > MACRO_AW) ? ADDR_W - MACRO_AW : 1;
  localparam int unsigned ROW_SLOTS = 1 << ROW_W;
`ifdef SRAM_OUT_REG_EN
  localparam int unsigned CAP       = 3;
`else
  localparam int unsigned CAP       = 2;
`endif
  localparam int unsigned PTR_W      = $clog2(CAP);
  localparam int unsigned FIFO_SLOTS = 1 << PTR_W;
  localparam int unsigned CNT_W      = 2;

  typedef struct packed {
    logic              err;
    logic [DATA_W-1:0] data;
  } rsp_t;

  // Request decode.
  logic                accept;
  logic                in_range;
  logic [ROW_W-1:0]    req_row;
  logic [MACRO_AW-1:0] req_madr;

  assign accept   = i_req_valid & o_req_ready;
  assign in_range = 32'(i_req_addr) < DEPTH;
  assign req_row  = ROW_W'(i_req_addr >> MACRO_AW);
  assign req_madr = i_req_addr[MACRO_AW-1:0];

  // Macro array; unpopulated row slots (non-power-of-2 DEPTH) read as zero.
  logic [ROW_SLOTS-1:0][DATA_W-1:0] row_q;

  for (genvar r = 0; r < ROW_SLOTS; r++) begin : g_row
    if (r < ROWS) begin : g_live
      logic row_me;
      assign row_me = accept & in_range & (req_row == ROW_W'(r));
      for (genvar c = 0; c < COLS; c++) begin : g_col
        sram_macro_tile u_tile (
          .clk  (i_clk),
          .mea  (row_me),
          .wea  (i_req_we),
          .adra (req_madr),
          .da   (i_req_wdata[c*MACRO_W +: MACRO_W]),
          .wema (i_req_bmask[c*MACRO_W +: MACRO_W]),
          .qa   (row_q[r][c*MACRO_W +: MACRO_W])
        );
      end
    end else begin : g_empty
      assign row_q[r] = '0;
    end
  end

  // Read stage 1: remember which row (or error) the macro output belongs to.
  logic             rd_v1;
  logic             rd_err1;
  logic [ROW_W-1:0] rd_row1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_v1   <= 1'b0;
      rd_err1 <= 1'b0;
      rd_row1 <= '0;
    end else begin
      rd_v1 <= accept & ~i_req_we;
      if (accept & ~i_req_we) begin
        rd_err1 <= ~in_range;
        rd_row1 <= req_row;
      end
    end
  end

  rsp_t mux_rsp;

  always_comb begin
    mux_rsp      = '0;
    mux_rsp.err  = rd_err1;
    mux_rsp.data = rd_err1 ? '0 : row_q[rd_row1];
  end

  // Final pipeline stage feeding the FIFO / fall-through path.
  logic             last_v;
  rsp_t             last_rsp;
  logic [CNT_W-1:0] inflight;

`ifdef SRAM_OUT_REG_EN
  logic rd_v2;
  rsp_t rd_rsp2;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_v2   <= 1'b0;
      rd_rsp2 <= '0;
    end else begin
      rd_v2 <= rd_v1;
      if (rd_v1) begin
        rd_rsp2 <= mux_rsp;
      end
    end
  end

  assign last_v   = rd_v2;
  assign last_rsp = rd_rsp2;
  assign inflight = CNT_W'(rd_v1) + CNT_W'(rd_v2);
`else
  assign last_v   = rd_v1;
  assign last_rsp = mux_rsp;
  assign inflight = CNT_W'(rd_v1);
`endif

  // Response skid FIFO; an empty FIFO lets the pipeline output fall through.
  rsp_t             fifo_mem [FIFO_SLOTS];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] fifo_cnt;
  logic             fifo_empty;
  logic             pop;
  logic             enq;
  logic             deq;
  rsp_t             head;
  logic [CNT_W-1:0] occ;

  assign fifo_empty = (fifo_cnt == '0);
  assign head       = fifo_empty ? last_rsp : fifo_mem[rd_ptr];
  assign pop        = o_rsp_valid & i_rsp_ready;
  assign deq        = pop & ~fifo_empty;
  assign enq        = last_v & ~(fifo_empty & i_rsp_ready);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (enq) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (deq) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      fifo_cnt <= fifo_cnt + CNT_W'(enq) - CNT_W'(deq);
    end
  end

  always_ff @(posedge i_clk) begin
    if (enq) begin
      fifo_mem[wr_ptr] <= last_rsp;
    end
  end

  // Buffered plus in-flight reads never exceed the FIFO capacity.
  assign occ         = fifo_cnt + inflight;
  assign o_req_ready = (occ < CNT_W'(CAP));
  assign o_rsp_valid = ~fifo_empty | last_v;
  assign o_rsp_rdata = o_rsp_valid ? head.data : '0;
  assign o_rsp_err   = o_rsp_valid & head.err;

endmodule

// File: tb/tb_sram_banked_mem.sv
// Self-checking bench for sram_banked_mem: a 64x4096 instance and a 64x3072
// instance (out-of-range addresses) against a word-array / response-queue model.
module tb_sram_banked_mem;

`ifdef SRAM_OUT_REG_EN
  localparam int LAT = 2;
  localparam int CAP = 3;
`else
  localparam int LAT = 1;
  localparam int CAP = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel3k = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic        rsp_ready = 1'b0;
  logic [11:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [63:0] req_bmask = '0;

  logic        valid_a, valid_b, ready_a, ready_b, rvalid_a, rvalid_b, rerr_a, rerr_b;
  logic [63:0] rdata_a, rdata_b;

  assign valid_a = req_valid & ~sel3k;
  assign valid_b = req_valid & sel3k;

  always #5 clk = ~clk;

  sram_banked_mem #(.DATA_W(64), .DEPTH(4096)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(valid_a), .o_req_ready(ready_a),
    .i_req_we(req_we), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .i_req_bmask(req_bmask), .o_rsp_valid(rvalid_a), .i_rsp_ready(rsp_ready),
    .o_rsp_rdata(rdata_a), .o_rsp_err(rerr_a)
  );

  sram_banked_mem #(.DATA_W(64), .DEPTH(3072)) dut3k (
    .i_clk(clk), .i_rst(rst), .i_req_valid(valid_b), .o_req_ready(ready_b),
    .i_req_we(req_we), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .i_req_bmask(req_bmask), .o_rsp_valid(rvalid_b), .i_rsp_ready(rsp_ready),
    .o_rsp_rdata(rdata_b), .o_rsp_err(rerr_b)
  );

  // Reference model: word contents per instance and expected responses in order.
  logic [63:0] model_mem [2][4096];
  logic [64:0] pend [$];

  int n_checks = 0;
  int n_fail   = 0;

  // Per-cycle observations.
  logic        s_ready, s_rvalid, s_rerr, s_exp_ready, s_acc, s_pop, s_have_exp;
  logic [63:0] s_rdata;
  logic [64:0] s_exp;

  // One cycle: drive at posedge+1, sample at negedge, update model, return at next posedge+1.
  task automatic drive(input logic v, input logic we, input logic [11:0] a,
                       input logic [63:0] wd, input logic [63:0] bm, input logic rr);
    int depth;
    depth = sel3k ? 3072 : 4096;
    req_valid = v; req_we = we; req_addr = a; req_wdata = wd; req_bmask = bm; rsp_ready = rr;
    #4;
    s_ready  = sel3k ? ready_b  : ready_a;
    s_rvalid = sel3k ? rvalid_b : rvalid_a;
    s_rdata  = sel3k ? rdata_b  : rdata_a;
    s_rerr   = sel3k ? rerr_b   : rerr_a;
    s_exp_ready = (pend.size() < CAP);
    s_acc = v && s_ready;
    s_pop = s_rvalid && rr;
    s_have_exp = 1'b0;
    s_exp = '0;
    if (s_pop && pend.size() > 0) begin
      s_exp = pend.pop_front();
      s_have_exp = 1'b1;
    end
    if (s_acc) begin
      if (int'(a) < depth) begin
        if (we) model_mem[sel3k][a] = (model_mem[sel3k][a] & ~bm) | (wd & bm);
        else    pend.push_back({1'b0, model_mem[sel3k][a]});
      end else if (!we) begin
        pend.push_back({1'b1, 64'h0});
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (ready_a !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b exp 1", ready_a); end
    n_checks++;
    if (rvalid_a !== 1'b0 || rvalid_b !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b/%b exp 0/0", rvalid_a, rvalid_b);
    end
    n_checks++;
    if (rdata_a !== 64'h0) begin n_fail++; $display("FAIL reset_rdata: got %h exp 0", rdata_a); end
    n_checks++;
    if (rerr_a !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b exp 0", rerr_a); end
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    drive(1'b1, 1'b1, 12'h005, 64'hDEAD_BEEF_0123_4567, '1, 1'b1);
    n_checks++;
    if (s_ready !== s_exp_ready) begin n_fail++; $display("FAIL wr_ready: got %b exp %b", s_ready, s_exp_ready); end
    drive(1'b1, 1'b0, 12'h005, '0, '0, 1'b1);
    n_checks++;
    if (s_rvalid !== 1'b0) begin n_fail++; $display("FAIL rd_early_valid: got %b exp 0", s_rvalid); end
    for (int k = 1; k <= 3; k++) begin
      drive(1'b0, 1'b0, '0, '0, '0, 1'b1);
      n_checks++;
      if (s_rvalid !== (k == LAT)) begin
        n_fail++; $display("FAIL rd_latency cycle %0d: got valid %b exp %b", k, s_rvalid, (k == LAT));
      end
      if (s_pop) begin
        n_checks++;
        if (!s_have_exp || {s_rerr, s_rdata} !== s_exp) begin
          n_fail++; $display("FAIL rd_data: got err=%b data=%h exp err=%b data=%h", s_rerr, s_rdata, s_exp[64], s_exp[63:0]);
        end
      end
    end
  endtask

  task automatic test_bmask();
    int pops = 0;
    for (int i = 0; i < 7; i++) begin
      case (i)
        0:       drive(1'b1, 1'b1, 12'hC00, '1, '1, 1'b1);
        1:       drive(1'b1, 1'b1, 12'hC00, '0, 64'h0000_0000_FFFF_FFFF, 1'b1);
        2:       drive(1'b1, 1'b0, 12'hC00, '0, '0, 1'b1);
        default: drive(1'b0, 1'b0, '0, '0, '0, 1'b1);
      endcase
      n_checks++;
      if (s_ready !== s_exp_ready) begin n_fail++; $display("FAIL bmask_ready: got %b exp %b", s_ready, s_exp_ready); end
      if (s_pop) begin
        pops++;
        n_checks++;
        if (!s_have_exp || {s_rerr, s_rdata} !== s_exp) begin
          n_fail++; $display("FAIL bmask_rsp: got err=%b data=%h exp err=%b data=%h", s_rerr, s_rdata, s_exp[64], s_exp[63:0]);
        end
      end
    end
    n_checks++;
    if (pops !== 1) begin n_fail++; $display("FAIL bmask_count: got %0d responses exp 1", pops); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] da, db;
    da = {$urandom, $urandom};
    db = ~da;
    for (int i = 0; i < 9; i++) begin
      case (i)
        0:       drive(1'b1, 1'b1, 12'h3FF, da, '1, 1'b1);
        1:       drive(1'b1, 1'b0, 12'h3FF, '0, '0, 1'b1);
        2:       drive(1'b1, 1'b1, 12'h400, db, '1, 1'b1);
        3:       drive(1'b1, 1'b0, 12'h3FF, '0, '0, 1'b1);
        4:       drive(1'b1, 1'b0, 12'h400, '0, '0, 1'b1);
        default: drive(1'b0, 1'b0, '0, '0, '0, 1'b1);
      endcase
      n_checks++;
      if (s_ready !== s_exp_ready) begin n_fail++; $display("FAIL b2b_ready: got %b exp %b", s_ready, s_exp_ready); end
      if (s_pop) begin
        n_checks++;
        if (!s_have_exp || {s_rerr, s_rdata} !== s_exp) begin
          n_fail++; $display("FAIL b2b_rsp: got err=%b data=%h exp err=%b data=%h", s_rerr, s_rdata, s_exp[64], s_exp[63:0]);
        end
      end
    end
    n_checks++;
    if (pend.size() !== 0) begin n_fail++; $display("FAIL b2b_drain: %0d responses missing exp 0", pend.size()); end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    int pops = 0;
    logic have_prev = 1'b0;
    logic [64:0] prev = '0;
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 12'(i), 64'(i), '1, 1'b1);
    for (int c = 0; c < 8; c++) begin
      drive(acc < 4, 1'b0, 12'(acc), '0, '0, 1'b0);
      n_checks++;
      if (s_ready !== s_exp_ready) begin n_fail++; $display("FAIL bp_ready: got %b exp %b", s_ready, s_exp_ready); end
      if (s_acc) acc++;
      if (s_rvalid) begin
        if (have_prev) begin
          n_checks++;
          if ({s_rerr, s_rdata} !== prev) begin
            n_fail++; $display("FAIL bp_hold: got %h exp %h", {s_rerr, s_rdata}, prev);
          end
        end
        prev = {s_rerr, s_rdata};
        have_prev = 1'b1;
      end
    end
    n_checks++;
    if (acc !== CAP) begin n_fail++; $display("FAIL bp_accepts: got %0d exp %0d", acc, CAP); end
    for (int c = 0; c < 12; c++) begin
      drive(acc < 4, 1'b0, 12'(acc), '0, '0, 1'b1);
      if (s_acc) acc++;
      n_checks++;
      if (s_ready !== s_exp_ready) begin n_fail++; $display("FAIL bp_rel_ready: got %b exp %b", s_ready, s_exp_ready); end
      if (s_pop) begin
        pops++;
        n_checks++;
        if (!s_have_exp || {s_rerr, s_rdata} !== s_exp) begin
          n_fail++; $display("FAIL bp_rsp: got err=%b data=%h exp err=%b data=%h", s_rerr, s_rdata, s_exp[64], s_exp[63:0]);
        end
      end
    end
    n_checks++;
    if (pops !== 4) begin n_fail++; $display("FAIL bp_count: got %0d responses exp 4", pops); end
  endtask

  task automatic test_out_of_range();
    logic [11:0] addr_l [9];
    logic        we_l [9];
    addr_l = '{12'h000, 12'h400, 12'h800, 12'hC00, 12'hC00, 12'h000, 12'h400, 12'h800, 12'hFFF};
    we_l   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    sel3k = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (i < 9) drive(1'b1, we_l[i], addr_l[i], {$urandom, $urandom}, '1, 1'b1);
      else       drive(1'b0, 1'b0, '0, '0, '0, 1'b1);
      n_checks++;
      if (s_ready !== s_exp_ready) begin n_fail++; $display("FAIL oor_ready: got %b exp %b", s_ready, s_exp_ready); end
      if (s_pop) begin
        n_checks++;
        if (!s_have_exp || {s_rerr, s_rdata} !== s_exp) begin
          n_fail++; $display("FAIL oor_rsp: got err=%b data=%h exp err=%b data=%h", s_rerr, s_rdata, s_exp[64], s_exp[63:0]);
        end
      end
    end
    sel3k = 1'b0;
  endtask

  task automatic test_random();
    logic [11:0] pool [16];
    pool = '{12'h000, 12'h001, 12'h002, 12'h003, 12'h005, 12'h3FF, 12'h400, 12'h7FF,
             12'h800, 12'hBFF, 12'hC00, 12'hFFF, 12'h0, 12'h0, 12'h0, 12'h0};
    for (int i = 12; i < 16; i++) pool[i] = 12'($urandom_range(0, 4095));
    for (int i = 0; i < 420; i++) begin
      if (i < 16)
        drive(1'b1, 1'b1, pool[i], {$urandom, $urandom}, '1, 1'b1);
      else if (i < 410)
        drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4, pool[$urandom_range(0, 15)],
              {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 9) < 7);
      else
        drive(1'b0, 1'b0, '0, '0, '0, 1'b1);
      n_checks++;
      if (s_ready !== s_exp_ready) begin n_fail++; $display("FAIL rand_ready cycle %0d: got %b exp %b", i, s_ready, s_exp_ready); end
      if (s_pop) begin
        n_checks++;
        if (!s_have_exp || {s_rerr, s_rdata} !== s_exp) begin
          n_fail++; $display("FAIL rand_rsp cycle %0d: got err=%b data=%h exp err=%b data=%h", i, s_rerr, s_rdata, s_exp[64], s_exp[63:0]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int pops = 0;
    drive(1'b1, 1'b0, 12'h000, '0, '0, 1'b0);
    drive(1'b1, 1'b0, 12'h001, '0, '0, 1'b0);
    repeat (LAT + 1) drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
    n_checks++;
    if (s_rvalid !== 1'b1) begin n_fail++; $display("FAIL rstmid_buffered: got valid %b exp 1", s_rvalid); end
    rst = 1'b1;
    #1;
    n_checks++;
    if (rvalid_a !== 1'b0 || ready_a !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_async: got valid %b ready %b exp 0 1", rvalid_a, ready_a);
    end
    pend.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i == 0)      drive(1'b1, 1'b0, 12'h3FF, '0, '0, 1'b1);
      else if (i == 1) drive(1'b1, 1'b0, 12'h400, '0, '0, 1'b1);
      else             drive(1'b0, 1'b0, '0, '0, '0, 1'b1);
      n_checks++;
      if (s_ready !== s_exp_ready) begin n_fail++; $display("FAIL rstmid_ready: got %b exp %b", s_ready, s_exp_ready); end
      if (s_pop) begin
        pops++;
        n_checks++;
        if (!s_have_exp || {s_rerr, s_rdata} !== s_exp) begin
          n_fail++; $display("FAIL rstmid_rsp: got err=%b data=%h exp err=%b data=%h", s_rerr, s_rdata, s_exp[64], s_exp[63:0]);
        end
      end
    end
    n_checks++;
    if (pops !== 2) begin n_fail++; $display("FAIL rstmid_count: got %0d responses exp 2", pops); end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      model_mem[0][i] = '0;
      model_mem[1][i] = '0;
    end
    test_reset();
    test_write_read();
    test_bmask();
    test_back_to_back();
    test_backpressure();
    test_out_of_range();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
